// File: rtl/interp_pkg.sv
// Shared definitions for the interpolator comparison stages:
// measurement FSM encoding and a saturating unsigned add.
package interp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } stat_state_t;

   localparam int SAT_MAXW = 128;

   typedef struct packed {
      logic                ovf;
      logic [SAT_MAXW-1:0] sum;
   } sat_sum_t;

   // Adds two unsigned values and clamps the result to w bits of ones.
   // The w argument is a constant at every call site, so the limit folds away.
   function automatic sat_sum_t sat_add(input logic [SAT_MAXW-1:0] a,
                                        input logic [SAT_MAXW-1:0] b,
                                        input int unsigned         w);
      logic [SAT_MAXW:0] full;
      logic [SAT_MAXW:0] lim;
      sat_sum_t          r;
      full  = {1'b0, a} + {1'b0, b};
      lim   = ((SAT_MAXW+1)'(1) << w) - (SAT_MAXW+1)'(1);
      r.ovf = (full > lim);
      r.sum = r.ovf ? lim[SAT_MAXW-1:0] : full[SAT_MAXW-1:0];
      return r;
   endfunction

endpackage

// File: rtl/err_sq_pipe.sv
// Two-stage error pipe: S1 registers data-ref, S2 registers |diff| and its square.
// Two cycles from i_ce to valid; no backpressure, bubbles carry valid=0.
module err_sq_pipe #(
   parameter int INW = 28
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_ce,
   input  logic signed [INW-1:0] data,
   input  logic signed [INW-1:0] ref_data,
   output logic                  stage1_valid,
   output logic                  valid,
   output logic [INW:0]          mag,
   output logic [2*INW:0]        sq
);

   logic signed [INW:0] diff;
   logic signed [INW:0] diff_c;
   logic [INW:0]        mag_c;
   logic [2*INW:0]      sq_c;

   always_comb begin
      diff_c = $signed({data[INW-1], data}) - $signed({ref_data[INW-1], ref_data});
      mag_c  = diff[INW] ? $unsigned(-diff) : $unsigned(diff);
      // |diff| <= 2^INW, so the square always fits in 2*INW+1 bits
      sq_c   = (2*INW+1)'((2*INW+2)'(mag_c) * (2*INW+2)'(mag_c));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage1_valid <= 1'b0;
         diff         <= '0;
      end else begin
         stage1_valid <= i_ce;
         if (i_ce) diff <= diff_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         mag   <= '0;
         sq    <= '0;
      end else begin
         valid <= stage1_valid;
         if (stage1_valid) begin
            mag <= mag_c;
            sq  <= sq_c;
         end
      end
   end

endmodule

// File: rtl/interp_err_stats.sv
// Block error statistics: saturating sum of squared error and peak |error| over 2^LGN samples.
// o_valid rises 3 cycles after the last sample and holds stable results until i_ready.
module interp_err_stats #(
   parameter int INW  = 28,
   parameter int LGN  = 10,
   parameter int ACCW = 64
) (
   input  logic                  i_clk,
   input  logic                  i_areset_n,
   input  logic                  i_start,
   input  logic                  i_ce,
   input  logic signed [INW-1:0] i_data,
   input  logic signed [INW-1:0] i_ref,
   output logic                  o_busy,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ACCW-1:0]       o_sumsq,
   output logic [INW:0]          o_maxerr,
   output logic                  o_sat
);
   import interp_pkg::*;

   localparam int SQW = 2*INW + 1;
   localparam logic [LGN:0] LAST_IDX = {1'b0, {LGN{1'b1}}};

   stat_state_t     state;
   stat_state_t     state_nxt;
   logic            clr;
   logic            accept;
   logic [LGN:0]    cnt;

   logic            s1_vld;
   logic            s2_vld;
   logic [INW:0]    mag;
   logic [SQW-1:0]  sq;

   logic [ACCW-1:0] acc;
   logic [INW:0]    max_err;
   logic            sat;
   sat_sum_t        acc_sum;
   logic            unused_sum_hi;

   err_sq_pipe #(
      .INW (INW)
   ) u_pipe (
      .clk          (i_clk),
      .rst_n        (i_areset_n),
      .i_ce         (accept),
      .data         (i_data),
      .ref_data     (i_ref),
      .stage1_valid (s1_vld),
      .valid        (s2_vld),
      .mag          (mag),
      .sq           (sq)
   );

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      accept    = 1'b0;
      o_busy    = 1'b0;
      o_valid   = 1'b0;
      case (state)
         IDLE: begin
            // a sample arriving with i_start belongs to no block
            if (i_start) begin
               clr       = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            o_busy = 1'b1;
            accept = i_ce;
            if (i_ce && (cnt == LAST_IDX)) state_nxt = DRAIN;
         end
         DRAIN: begin
            o_busy = 1'b1;
            if (!s1_vld && !s2_vld) state_nxt = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n)  cnt <= '0;
      else if (clr)     cnt <= '0;
      else if (accept)  cnt <= cnt + (LGN+1)'(1);
   end

   always_comb acc_sum = sat_add(SAT_MAXW'(acc), SAT_MAXW'(sq), ACCW);
   assign unused_sum_hi = |acc_sum.sum[SAT_MAXW-1:ACCW];

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         acc     <= '0;
         max_err <= '0;
         sat     <= 1'b0;
      end else if (clr) begin
         acc     <= '0;
         max_err <= '0;
         sat     <= 1'b0;
      end else if (s2_vld) begin
         acc <= acc_sum.sum[ACCW-1:0];
         sat <= sat | acc_sum.ovf;
         if (mag > max_err) max_err <= mag;
      end
   end

   assign o_sumsq  = acc;
   assign o_maxerr = max_err;
   assign o_sat    = sat;

endmodule

// File: tb/tb_interp_err_stats.sv
// Bench for interp_err_stats: directed scenarios plus random blocks against a per-block model.
module tb_interp_err_stats;

   localparam int INW   = 8;
   localparam int LGN   = 2;
   localparam int ACCW  = 17;
   localparam int ACCW2 = 19;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic ce    = 1'b0;
   logic ready = 1'b0;
   logic signed [INW-1:0] data = '0;
   logic signed [INW-1:0] refv = '0;

   logic             busy1, valid1, sat1;
   logic [ACCW-1:0]  sumsq1;
   logic [INW:0]     maxerr1;
   logic             busy2, valid2, sat2;
   logic [ACCW2-1:0] sumsq2;
   logic [INW:0]     maxerr2;

   int errors = 0;
   int checks = 0;
   int d_q[$];
   int r_q[$];
   longint exp_sum1, exp_sum2;
   int     exp_max;
   bit     exp_sat1, exp_sat2;
   int     lat;

   always #5 clk = ~clk;

   interp_err_stats #(.INW(INW), .LGN(LGN), .ACCW(ACCW)) dut (
      .i_clk(clk), .i_areset_n(rst_n), .i_start(start), .i_ce(ce),
      .i_data(data), .i_ref(refv), .o_busy(busy1), .o_valid(valid1),
      .i_ready(ready), .o_sumsq(sumsq1), .o_maxerr(maxerr1), .o_sat(sat1));

   interp_err_stats #(.INW(INW), .LGN(LGN), .ACCW(ACCW2)) dut_wide (
      .i_clk(clk), .i_areset_n(rst_n), .i_start(start), .i_ce(ce),
      .i_data(data), .i_ref(refv), .o_busy(busy2), .o_valid(valid2),
      .i_ready(ready), .o_sumsq(sumsq2), .o_maxerr(maxerr2), .o_sat(sat2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: saturating accumulation of non-negative terms equals min(true sum, limit)
   function automatic void model();
      longint s;
      longint lim1, lim2;
      int     m;
      s = 0;
      m = 0;
      foreach (d_q[i]) begin
         int df, a;
         df = d_q[i] - r_q[i];
         a  = (df < 0) ? -df : df;
         s += longint'(a) * longint'(a);
         if (a > m) m = a;
      end
      lim1     = (longint'(1) << ACCW) - 1;
      lim2     = (longint'(1) << ACCW2) - 1;
      exp_max  = m;
      exp_sat1 = (s > lim1);
      exp_sat2 = (s > lim2);
      exp_sum1 = exp_sat1 ? lim1 : s;
      exp_sum2 = exp_sat2 ? lim2 : s;
   endfunction

   task automatic set4(input int d0, input int d1, input int d2, input int d3,
                       input int r0, input int r1, input int r2, input int r3);
      d_q = '{d0, d1, d2, d3};
      r_q = '{r0, r1, r2, r3};
   endtask

   // Optionally starts a block (with a stray i_ce alongside i_start), sends d_q/r_q with
   // gap idle cycles between samples, then waits (bounded) for o_valid, keeping junk i_ce
   // asserted while waiting if requested.
   task automatic run_block(input bit do_start, input int gap, input bit junk);
      if (do_start) begin
         start = 1'b1;
         ce    = junk;
         data  = INW'(77);
         refv  = INW'(-20);
         tick();
         start = 1'b0;
         ce    = 1'b0;
      end
      for (int i = 0; i < d_q.size(); i++) begin
         ce   = 1'b1;
         data = INW'(d_q[i]);
         refv = INW'(r_q[i]);
         tick();
         ce = 1'b0;
         if (i != d_q.size() - 1) repeat (gap) tick();
      end
      ce   = junk;
      data = INW'(99);
      refv = INW'(-99);
      lat  = 0;
      while (!valid1 && lat < 20) begin
         tick();
         lat++;
      end
      ce = 1'b0;
      model();
   endtask

   task automatic accept_results();
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid1); end
      checks++; if (sumsq1 !== '0 || maxerr1 !== '0 || sat1 !== 1'b0)
         begin errors++; $display("FAIL reset_results: got sumsq=%0d maxerr=%0d sat=%b want 0/0/0", sumsq1, maxerr1, sat1); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy1 !== 1'b0 || valid1 !== 1'b0)
         begin errors++; $display("FAIL idle_after_reset: got busy=%b valid=%b want 0/0", busy1, valid1); end
   endtask

   task automatic test_zero_error();
      set4(5, -3, 100, -128, 5, -3, 100, -128);
      run_block(1'b1, 0, 1'b1);
      checks++; if (lat !== 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", lat); end
      checks++; if (sumsq1 !== exp_sum1[ACCW-1:0] || maxerr1 !== (INW+1)'(exp_max) || sat1 !== exp_sat1)
         begin errors++; $display("FAIL zero_results: got %0d/%0d/%b want %0d/%0d/%b", sumsq1, maxerr1, sat1, exp_sum1, exp_max, exp_sat1); end
      accept_results();
      checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0)
         begin errors++; $display("FAIL zero_accept: got valid=%b busy=%b want 0/0", valid1, busy1); end
   endtask

   task automatic test_gaps();
      set4(10, -5, 3, 0, 0, 0, 0, 0);
      run_block(1'b1, 1, 1'b1);
      checks++; if (lat !== 3) begin errors++; $display("FAIL gap_latency: got %0d want 3", lat); end
      checks++; if (sumsq1 !== 17'd134 || sumsq1 !== exp_sum1[ACCW-1:0])
         begin errors++; $display("FAIL gap_sumsq: got %0d want 134", sumsq1); end
      checks++; if (maxerr1 !== 9'd10 || sat1 !== 1'b0)
         begin errors++; $display("FAIL gap_max_sat: got %0d/%b want 10/0", maxerr1, sat1); end
      accept_results();
   endtask

   task automatic test_saturation();
      set4(127, 127, 127, 127, -128, -128, -128, -128);
      run_block(1'b1, 0, 1'b0);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sat_latency: got %0d want 3", lat); end
      checks++; if (sumsq1 !== 17'h1FFFF || sat1 !== 1'b1 || maxerr1 !== 9'd255)
         begin errors++; $display("FAIL sat_narrow: got %0d/%0d/%b want 131071/255/1", sumsq1, maxerr1, sat1); end
      checks++; if (sumsq2 !== 19'd260100 || sat2 !== 1'b0 || valid2 !== 1'b1)
         begin errors++; $display("FAIL sat_wide: got %0d/%b valid=%b want 260100/0/1", sumsq2, sat2, valid2); end
      // left in DONE for the backpressure scenario
   endtask

   task automatic test_backpressure();
      for (int c = 0; c < 10; c++) begin
         start = (c == 5);
         tick();
         start = 1'b0;
         checks++; if (valid1 !== 1'b1 || sumsq1 !== exp_sum1[ACCW-1:0] || maxerr1 !== (INW+1)'(exp_max) || sat1 !== exp_sat1)
            begin errors++; $display("FAIL hold_cycle%0d: got valid=%b %0d/%0d/%b want 1 %0d/%0d/%b", c, valid1, sumsq1, maxerr1, sat1, exp_sum1, exp_max, exp_sat1); end
      end
      accept_results();
      checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0 || sumsq1 !== exp_sum1[ACCW-1:0] || sat1 !== exp_sat1)
         begin errors++; $display("FAIL idle_hold: got valid=%b busy=%b sumsq=%0d sat=%b want 0/0/%0d/%b", valid1, busy1, sumsq1, sat1, exp_sum1, exp_sat1); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (busy1 !== 1'b1 || sumsq1 !== '0 || maxerr1 !== '0 || sat1 !== 1'b0)
         begin errors++; $display("FAIL restart_clear: got busy=%b %0d/%0d/%b want 1 0/0/0", busy1, sumsq1, maxerr1, sat1); end
      set4(3, -7, 20, 1, 1, 2, -4, 1);
      run_block(1'b0, 0, 1'b0);
      checks++; if (lat !== 3 || sumsq1 !== exp_sum1[ACCW-1:0] || maxerr1 !== (INW+1)'(exp_max) || sat1 !== 1'b0)
         begin errors++; $display("FAIL restart_block: got lat=%0d %0d/%0d/%b want 3 %0d/%0d/0", lat, sumsq1, maxerr1, sat1, exp_sum1, exp_max); end
      accept_results();
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      ce = 1'b1; data = INW'(50);  refv = INW'(0); tick();
      ce = 1'b1; data = INW'(-60); refv = INW'(0); tick();
      ce = 1'b0;
      repeat (2) tick();
      checks++; if (sumsq1 !== 17'd6100 || maxerr1 !== 9'd60 || busy1 !== 1'b1)
         begin errors++; $display("FAIL partial_acc: got %0d/%0d busy=%b want 6100/60/1", sumsq1, maxerr1, busy1); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy1 !== 1'b0 || valid1 !== 1'b0 || sumsq1 !== '0 || maxerr1 !== '0 || sat1 !== 1'b0 || sumsq2 !== '0)
         begin errors++; $display("FAIL async_reset: got busy=%b valid=%b %0d/%0d/%b want 0/0 0/0/0", busy1, valid1, sumsq1, maxerr1, sat1); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      set4(1, 1, 1, 1, 0, 0, 0, 0);
      run_block(1'b1, 0, 1'b0);
      checks++; if (lat !== 3 || sumsq1 !== 17'd4 || maxerr1 !== 9'd1 || sat1 !== 1'b0)
         begin errors++; $display("FAIL post_reset_block: got lat=%0d %0d/%0d/%b want 3 4/1/0", lat, sumsq1, maxerr1, sat1); end
      accept_results();
   endtask

   task automatic test_wide_exact();
      set4(-128, -128, -128, -128, 127, 127, 127, 127);
      run_block(1'b1, 0, 1'b0);
      checks++; if (sumsq2 !== 19'd260100 || sat2 !== 1'b0 || maxerr2 !== 9'd255)
         begin errors++; $display("FAIL wide_exact: got %0d/%0d/%b want 260100/255/0", sumsq2, maxerr2, sat2); end
      checks++; if (sumsq1 !== 17'h1FFFF || sat1 !== 1'b1)
         begin errors++; $display("FAIL wide_narrow_sat: got %0d/%b want 131071/1", sumsq1, sat1); end
      accept_results();
   endtask

   task automatic test_random();
      for (int b = 0; b < 16; b++) begin
         d_q.delete();
         r_q.delete();
         for (int i = 0; i < (1 << LGN); i++) begin
            d_q.push_back(int'($urandom_range(255, 0)) - 128);
            r_q.push_back(int'($urandom_range(255, 0)) - 128);
         end
         run_block(1'b1, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
         checks++; if (lat !== 3) begin errors++; $display("FAIL rand%0d_latency: got %0d want 3", b, lat); end
         checks++; if (sumsq1 !== exp_sum1[ACCW-1:0] || maxerr1 !== (INW+1)'(exp_max) || sat1 !== exp_sat1)
            begin errors++; $display("FAIL rand%0d_narrow: got %0d/%0d/%b want %0d/%0d/%b", b, sumsq1, maxerr1, sat1, exp_sum1, exp_max, exp_sat1); end
         checks++; if (sumsq2 !== exp_sum2[ACCW2-1:0] || maxerr2 !== (INW+1)'(exp_max) || sat2 !== exp_sat2)
            begin errors++; $display("FAIL rand%0d_wide: got %0d/%0d/%b want %0d/%0d/%b", b, sumsq2, maxerr2, sat2, exp_sum2, exp_max, exp_sat2); end
         repeat ($urandom_range(3, 0)) tick();
         accept_results();
         checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0)
            begin errors++; $display("FAIL rand%0d_accept: got valid=%b busy=%b want 0/0", b, valid1, busy1); end
      end
   endtask

   initial begin
      test_reset();
      test_zero_error();
      test_gaps();
      test_saturation();
      test_backpressure();
      test_async_reset();
      test_wide_exact();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
